// File: rtl/video_timing_gen.sv
// Raster timing source: pixel enable, sync/blank decode and registered colour.
// Optional VIDEO_TIMING_TESTPAT_EN adds test_en and an 8-bar colour pattern.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned H_FP     = 8,
    parameter int unsigned H_SYNC   = 32,
    parameter int unsigned H_BP     = 40,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 15,
    parameter int unsigned CE_DIV   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef VIDEO_TIMING_TESTPAT_EN
    input  logic        test_en,
`endif
    input  logic [11:0] pix_data,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        ce_pix,
    output logic        frame_start,
    output logic        HBlank,
    output logic        VBlank,
    output logic        HSync,
    output logic        VSync,
    output logic [3:0]  VGA_R4,
    output logic [3:0]  VGA_G4,
    output logic [3:0]  VGA_B4
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [8:0] H_A   = 9'(H_ACTIVE);
    localparam logic [8:0] H_SS  = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0] H_SE  = 9'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0] H_END = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_A   = 9'(V_ACTIVE);
    localparam logic [8:0] V_SS  = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] V_SE  = 9'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [8:0] V_END = 9'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_END = DW'(CE_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [8:0]    hc_q, hc_d;
    logic [8:0]    vc_q, vc_d;
    logic          hblank_q, vblank_q, hsync_q, vsync_q;
    logic [11:0]   rgb_q, rgb_d, rgb_src;
    logic          hblank, vblank, hsync, vsync;

    assign ce_pix      = (div_q == DIV_END);
    assign frame_start = ce_pix && (hc_q == 9'd0) && (vc_q == 9'd0);
    assign pix_x       = hc_q;
    assign pix_y       = vc_q;

    assign hblank = (hc_q >= H_A);
    assign hsync  = (hc_q >= H_SS) && (hc_q < H_SE);
    assign vblank = (vc_q >= V_A);
    assign vsync  = (vc_q >= V_SS) && (vc_q < V_SE);

    always_comb begin
        rgb_src = pix_data;
`ifdef VIDEO_TIMING_TESTPAT_EN
        // bar index is hc[7:5]; each bit saturates one channel
        if (test_en) begin
            rgb_src = {{4{hc_q[7]}}, {4{hc_q[6]}}, {4{hc_q[5]}}};
        end
`endif
        rgb_d = (hblank || vblank) ? 12'h000 : rgb_src;
    end

    always_comb begin
        div_d = ce_pix ? '0 : div_q + 1'b1;
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (ce_pix) begin
            if (hc_q == H_END) begin
                hc_d = 9'd0;
                vc_d = (vc_q == V_END) ? 9'd0 : vc_q + 9'd1;
            end else begin
                hc_d = hc_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            hc_q     <= 9'd0;
            vc_q     <= 9'd0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            rgb_q    <= 12'h000;
        end else begin
            div_q <= div_d;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            if (ce_pix) begin
                hblank_q <= hblank;
                vblank_q <= vblank;
                hsync_q  <= hsync;
                vsync_q  <= vsync;
                rgb_q    <= rgb_d;
            end
        end
    end

    assign HBlank = hblank_q;
    assign VBlank = vblank_q;
    assign HSync  = hsync_q;
    assign VSync  = vsync_q;
    assign VGA_R4 = rgb_q[11:8];
    assign VGA_G4 = rgb_q[7:4];
    assign VGA_B4 = rgb_q[3:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with a shortened vertical raster.
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        test_en;
    logic [11:0] pix_data;
    logic [8:0]  pix_x, pix_y;
    logic        ce_pix, frame_start;
    logic        HBlank, VBlank, HSync, VSync;
    logic [3:0]  VGA_R4, VGA_G4, VGA_B4;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int c0, c1, n;
    bit ok;

    video_timing_gen #(
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef VIDEO_TIMING_TESTPAT_EN
        .test_en(test_en),
`endif
        .pix_data(pix_data),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .ce_pix(ce_pix),
        .frame_start(frame_start),
        .HBlank(HBlank),
        .VBlank(VBlank),
        .HSync(HSync),
        .VSync(VSync),
        .VGA_R4(VGA_R4),
        .VGA_G4(VGA_G4),
        .VGA_B4(VGA_B4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wire [15:0] outs = {HBlank, VBlank, HSync, VSync, VGA_R4, VGA_G4, VGA_B4};

    typedef struct {
        int          y;
        int          x;
        logic [11:0] pix;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stop on the ce_pix cycle addressing (x,y); give up after ~1 frame.
    task automatic goto(input int x, input int y);
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            if (ce_pix && pix_x == 9'(x) && pix_y == 9'(y)) begin
                ok = 1;
                break;
            end
            step();
        end
        chk($sformatf("reach_%0d_%0d", x, y), 32'(ok), 32'd1);
        if (!ok) summary();
    endtask

    task automatic apply(input string nm, input int x, input int y,
                         input logic [11:0] pix, input logic [15:0] exp);
        goto(x, y);
        pix_data = pix;
        step();
        chk(nm, 32'(outs), 32'(exp));
    endtask

    initial begin
        tbl[0]  = '{0,   0, 12'hA5C, 16'h0A5C};
        tbl[1]  = '{0, 319, 12'h123, 16'h0123};
        tbl[2]  = '{0, 320, 12'hA5C, 16'h8000};
        tbl[3]  = '{0, 327, 12'hFFF, 16'h8000};
        tbl[4]  = '{0, 328, 12'hFFF, 16'hA000};
        tbl[5]  = '{0, 359, 12'hFFF, 16'hA000};
        tbl[6]  = '{0, 360, 12'hFFF, 16'h8000};
        tbl[7]  = '{0, 399, 12'hFFF, 16'h8000};
        tbl[8]  = '{1,   0, 12'hA5C, 16'h0A5C};
        tbl[9]  = '{5, 100, 12'hFFF, 16'h0FFF};
        tbl[10] = '{6,   0, 12'hFFF, 16'h4000};
        tbl[11] = '{6, 329, 12'hFFF, 16'hE000};
        tbl[12] = '{7,  10, 12'hFFF, 16'h5000};
        tbl[13] = '{8, 399, 12'hFFF, 16'hD000};
        tbl[14] = '{9,   0, 12'hFFF, 16'h4000};
        tbl[15] = '{10, 399, 12'hFFF, 16'hC000};

        reset_n  = 1'b0;
        test_en  = 1'b0;
        pix_data = 12'h000;
        repeat (3) step();
        chk("rst_outs", 32'(outs), 32'h0000C000);
        chk("rst_ce", 32'(ce_pix), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_xy", 32'({pix_y, pix_x}), 32'd0);

        reset_n = 1'b1;
        step();
        chk("ce_clk1", 32'(ce_pix), 32'd0);
        step();
        chk("ce_clk2", 32'(ce_pix), 32'd0);
        step();
        chk("ce_clk3", 32'(ce_pix), 32'd1);
        chk("fs_clk3", 32'(frame_start), 32'd1);
        c0 = cyc;

        for (int i = 0; i < 16; i++) begin
            apply($sformatf("vec%0d_y%0d_x%0d", i, tbl[i].y, tbl[i].x),
                  tbl[i].x, tbl[i].y, tbl[i].pix, tbl[i].exp);
        end

        n = 0;
        while (!frame_start && n < 20) begin
            step();
            n++;
        end
        c1 = cyc;
        chk("frame_period", 32'(c1 - c0), 32'd17600);

        n = 0;
        do begin
            step();
            n++;
        end while (!ce_pix && n < 10);
        chk("ce_period", 32'(n), 32'd4);
        chk("ce_next_x", 32'(pix_x), 32'd1);

`ifdef VIDEO_TIMING_TESTPAT_EN
        test_en = 1'b1;
        apply("tp_hc0",   0, 1, 12'h5A3, 16'h0000);
        apply("tp_hc64",  64, 1, 12'h5A3, 16'h00F0);
        apply("tp_hc96",  96, 1, 12'h5A3, 16'h00FF);
        apply("tp_hc224", 224, 1, 12'h5A3, 16'h0FFF);
        apply("tp_hc256", 256, 1, 12'h5A3, 16'h0000);
        apply("tp_hblank", 330, 1, 12'h5A3, 16'hA000);
        test_en = 1'b0;
`endif

        apply("pre_rst", 150, 3, 12'h3C7, 16'h03C7);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'(outs), 32'h0000C000);
        chk("mid_rst_xy", 32'({pix_y, pix_x}), 32'd0);
        chk("mid_rst_ce", 32'(ce_pix), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("rel_fs_clk2", 32'(frame_start), 32'd0);
        step();
        chk("rel_fs_clk3", 32'(frame_start), 32'd1);
        chk("rel_xy", 32'({pix_y, pix_x}), 32'd0);

        summary();
    end

endmodule
